mac_result_collector: RTL

- Consumer end of the fixed-latency MAC datapath. The multiply-add pipeline cannot stall; its valid flag is delayed through a shift-register valid pipeline.
- This block gates op issue into the MAC with a credit count, so every result is guaranteed a slot.
- It captures each valid-tagged result into a first-word-fall-through (FWFT) FIFO and presents it downstream on a ready/valid handshake.

---
 rtl/mac_result_collector.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mac_result_collector.sv
// Result collector for a fixed-latency, non-stalling MAC pipeline.
// Credit-gates op issue so every returning result has a slot in the FWFT FIFO.
module mac_result_collector #(
  parameter int Stages    = 7,
  parameter int DataWidth = 32,
  parameter int Depth     = 8
) (
  input  logic                         clk,
  input  logic                         aclr,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic                         pipe_valid,
  input  logic [DataWidth-1:0]         pipe_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DataWidth-1:0]         out_data,
  output logic [$clog2(Depth+1)-1:0]   inflight,
  output logic [$clog2(Depth+1)-1:0]   fifo_count,
  output logic                         err_orphan,
  output logic                         err_drop
);

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  // Stages only sets the throughput the credit pool can sustain; nothing is built from it.
  if (Stages > Depth) begin : g_credit_limited
  end

  logic [CW-1:0]        inflight_q, inflight_d;
  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 err_orphan_q, err_orphan_d;
  logic                 err_drop_q, err_drop_d;
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] mem_d [Depth];

  logic          full;
  logic          pop;
  logic          wr_en;
  logic          issue_fire;
  logic          returned;
  logic [CW:0]   credit_used;

  // Registered state only; a compare (not credits != 0) stays safe if orphans overfill.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign issue_ready = (credit_used < (CW + 1)'(Depth)) && !aclr;

  assign out_valid  = (count_q != '0);
  assign full       = (count_q == CW'(Depth));
  assign pop        = out_valid && out_ready;
  assign issue_fire = issue_valid && issue_ready;
  assign returned   = pipe_valid && (inflight_q != '0);
  assign wr_en      = pipe_valid && (!full || pop);

  always_comb begin
    inflight_d   = inflight_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    err_orphan_d = err_orphan_q;
    err_drop_d   = err_drop_q;
    mem_d        = mem_q;

    case ({issue_fire, returned})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wr_en) begin
      mem_d[wr_ptr_q] = pipe_data;
      wr_ptr_d        = (wr_ptr_q == PW'(Depth - 1)) ? '0 : wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(Depth - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    if (pipe_valid && (inflight_q == '0)) err_orphan_d = 1'b1;
    if (pipe_valid && !wr_en)             err_drop_d   = 1'b1;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      inflight_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      err_orphan_q <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      err_orphan_q <= err_orphan_d;
      err_drop_q   <= err_drop_d;
    end
  end

  // Storage needs no reset: out_data is only meaningful while out_valid is set.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_data   = mem_q[rd_ptr_q];
  assign inflight   = inflight_q;
  assign fifo_count = count_q;
  assign err_orphan = err_orphan_q;
  assign err_drop   = err_drop_q;

endmodule
